count_pulse_gen: RTL and testbench

Upstream stage feeding the 4-bit cascaded counter's enable input. Converts either a raw, bouncy push-button or an internal prescaled timebase into clean single-cycle count-enable pulses. Also keeps a running tally of pulses issued. Output `en_out` connects directly to the counter's `en`, and the block shares the counter's `clk` and `clr`.

---
 rtl/signal_sages_pkg.sv | 16 +
 rtl/sync2.sv | 24 ++
 rtl/count_pulse_gen.sv | 130 +++++++++++++
 tb/tb_count_pulse_gen.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/signal_sages_pkg.sv
// rtl/signal_sages_pkg.sv - shared types and constants for the count pulse generator
package signal_sages_pkg;

  localparam int CNT_W = 8;

  localparam logic MODE_FREE   = 1'b0;
  localparam logic MODE_MANUAL = 1'b1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for an asynchronous single-bit level
module sync2 (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

// File: rtl/count_pulse_gen.sv
// rtl/count_pulse_gen.sv - debounced button or prescaled timebase to single-cycle count enables
module count_pulse_gen
  import signal_sages_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PRESCALE_DIV    = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             btn_raw,
  input  logic             mode,
  input  logic             run,
  output logic             en_out,
  output logic             btn_level,
  output logic [CNT_W-1:0] pulse_cnt
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRESCALE_DIV - 1);

  logic             w_btn_s;
  db_state_t        r_state;
  db_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_db_cnt;
  logic [CNT_W-1:0] w_db_cnt_nxt;
  logic             w_press_done;
  logic             r_level;
  logic             w_level_nxt;
  logic [CNT_W-1:0] r_pre_cnt;
  logic             w_free_active;
  logic             w_pre_wrap;
  logic             w_fire;
  logic             r_en;
  logic [CNT_W-1:0] r_pulse_cnt;

  sync2 u_sync (
    .clk (clk),
    .clr (clr),
    .d   (btn_raw),
    .q   (w_btn_s)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= IDLE;
      r_db_cnt <= '0;
      r_level  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_db_cnt <= w_db_cnt_nxt;
      r_level  <= w_level_nxt;
    end
  end

  // Only the PRESS_WAIT -> HELD edge is a press; bouncing back to HELD from RELEASE_WAIT is not.
  always_comb begin
    w_state_nxt  = r_state;
    w_db_cnt_nxt = r_db_cnt;
    w_press_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_btn_s) begin
          w_state_nxt  = PRESS_WAIT;
          w_db_cnt_nxt = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_btn_s) begin
          w_state_nxt = IDLE;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt  = HELD;
          w_press_done = 1'b1;
        end else begin
          w_db_cnt_nxt = r_db_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!w_btn_s) begin
          w_state_nxt  = RELEASE_WAIT;
          w_db_cnt_nxt = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_btn_s) begin
          w_state_nxt = HELD;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_db_cnt_nxt = r_db_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_db_cnt_nxt = '0;
      end
    endcase
    w_level_nxt = (w_state_nxt == HELD) || (w_state_nxt == RELEASE_WAIT);
  end

  assign w_free_active = (mode == MODE_FREE) && run;
  assign w_pre_wrap    = w_free_active && (r_pre_cnt == PRE_LAST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_pre_cnt <= '0;
    end else if (!w_free_active || w_pre_wrap) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + 1'b1;
    end
  end

  // mode picks exactly one source, so two enables can never land in the same cycle.
  assign w_fire = (mode == MODE_MANUAL) ? w_press_done : w_pre_wrap;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_en        <= 1'b0;
      r_pulse_cnt <= '0;
    end else begin
      r_en        <= w_fire;
      r_pulse_cnt <= r_pulse_cnt + {{(CNT_W-1){1'b0}}, w_fire};
    end
  end

  assign en_out    = r_en;
  assign btn_level = r_level;
  assign pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_count_pulse_gen.sv
// tb/tb_count_pulse_gen.sv - scoreboard bench for count_pulse_gen
`timescale 1ns/1ps
module tb_count_pulse_gen;
  import signal_sages_pkg::*;

  localparam int DB = 16;
  localparam int PD = 4;

  logic       clk = 1'b0;
  logic       clr;
  logic       btn_raw;
  logic       mode;
  logic       run;
  logic       en_out;
  logic       btn_level;
  logic [7:0] pulse_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  typedef struct {
    int         at;
    logic [7:0] cnt;
    bit         lvl;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] exp_cnt;

  count_pulse_gen #(
    .DEBOUNCE_CYCLES (DB),
    .PRESCALE_DIV    (PD)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .btn_raw   (btn_raw),
    .mode      (mode),
    .run       (run),
    .en_out    (en_out),
    .btn_level (btn_level),
    .pulse_cnt (pulse_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, edge_cnt);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int at, input bit lvl);
    exp_cnt = exp_cnt + 8'd1;
    sb.push_back('{at, exp_cnt, lvl});
  endtask

  task automatic drain(input int budget);
    int b;
    b = 0;
    while (sb.size() > 0 && b < budget) begin
      step(1);
      b++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Every en_out pulse must match the oldest expectation in time and tally.
  always @(negedge clk) begin
    if (!clr && en_out) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", pulse_cnt, 0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_edge", edge_cnt, mon_e.at);
        check("pulse_cnt", pulse_cnt, mon_e.cnt);
        if (mon_e.lvl) check("level_at_pulse", btn_level, 1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    clr     = 1'b1;
    btn_raw = 1'b1;
    mode    = MODE_MANUAL;
    run     = 1'b0;
    exp_cnt = 8'd0;
    step(3);
    check("rst_en_out", en_out, 0);
    check("rst_level", btn_level, 0);
    check("rst_cnt", pulse_cnt, 0);
    check("rst_state", 32'(dut.r_state), 32'(IDLE));
    check("rst_sync", dut.u_sync.q, 0);

    // Button already held when reset releases.
    t0 = edge_cnt;
    clr = 1'b0;
    push(t0 + 3 + DB, 1);
    drain(40);
    check("cnt_after_reset", pulse_cnt, 1);

    step(180);
    check("hold_level", btn_level, 1);
    check("hold_no_repeat", pulse_cnt, 1);

    btn_raw = 1'b0;
    t0 = edge_cnt;
    step(DB + 2);
    check("release_level_before", btn_level, 1);
    step(1);
    check("release_level_after", btn_level, 0);

    for (int i = 0; i < 12; i++) begin
      btn_raw = (i % 2 == 0);
      step(5);
    end
    check("bounce_level", btn_level, 0);
    check("bounce_cnt", pulse_cnt, 1);
    btn_raw = 1'b1;
    t0 = edge_cnt;
    push(t0 + 3 + DB, 1);
    drain(40);

    step(10);
    for (int i = 0; i < 4; i++) begin
      btn_raw = (i % 2 == 1);
      step(2);
    end
    btn_raw = 1'b0;
    t0 = edge_cnt;
    step(DB + 2);
    check("bounced_release_before", btn_level, 1);
    step(1);
    check("bounced_release_after", btn_level, 0);
    check("bounced_release_cnt", pulse_cnt, 2);

    mode = MODE_FREE;
    run  = 1'b1;
    t0 = edge_cnt;
    for (int k = 1; k <= 10; k++) push(t0 + PD * k, 0);
    step(40);
    run = 1'b0;
    drain(5);
    check("free40_cnt", pulse_cnt, 12);
    step(2);
    check("free40_pre", dut.r_pre_cnt, 0);

    run = 1'b1;
    t0 = edge_cnt;
    for (int k = 1; k <= 5; k++) push(t0 + PD * k, 0);
    step(22);
    run = 1'b0;
    step(20);
    drain(2);
    check("drop_run_pre", dut.r_pre_cnt, 0);
    check("drop_run_cnt", pulse_cnt, 17);

    run = 1'b1;
    t0 = edge_cnt;
    for (int k = 1; k <= 257; k++) push(t0 + PD * k, 0);
    step(PD * 257);
    run = 1'b0;
    drain(5);
    check("wrap_cnt", pulse_cnt, 18);

    run = 1'b1;
    step(2);
    clr = 1'b1;
    #1;
    check("midrst_en_out", en_out, 0);
    check("midrst_cnt", pulse_cnt, 0);
    check("midrst_pre", dut.r_pre_cnt, 0);
    exp_cnt = 8'd0;
    run     = 1'b0;
    mode    = MODE_MANUAL;
    btn_raw = 1'b1;
    step(3);
    t0 = edge_cnt;
    clr = 1'b0;
    push(t0 + 3 + DB, 1);
    drain(40);
    check("midrst_repress_cnt", pulse_cnt, 1);

    mode = MODE_FREE;
    step(20);
    mode = MODE_MANUAL;
    step(30);
    check("modesw_level", btn_level, 1);
    check("modesw_cnt", pulse_cnt, 1);

    btn_raw = 1'b0;
    step(40);
    btn_raw = 1'b1;
    t0 = edge_cnt;
    push(t0 + 3 + DB, 1);
    drain(40);
    check("modesw_new_press_cnt", pulse_cnt, 2);

    step(5);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
